affine_addr_gen: RTL and testbench

Parametrised N-dimensional affine address generator for the scan pipeline. Generalises the fixed two-level, 16-bit counter/stride nest to `DIMS` dimensions of `WIDTH` bits, each with its own extent and stride. Adds a latched configuration, start/done control and an output-valid flag. It drives memory address ports from the per-step `step` strobe, exactly where the hand-built nested scans sit today.

---
 rtl/affine_addr_gen.sv | 126 ++++++++++++
 tb/tb_affine_addr_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator: addr = offset + sum(cnt_i*stride_i), wrapping mod 2^WIDTH.
// Configuration is latched on start; one scan point is consumed per step.
//
// state | meaning
// IDLE  | no scan active, step ignored
// RUN   | addr_out is a live scan point
// DONE  | one-cycle done pulse after the final point
module affine_addr_gen #(
  parameter int WIDTH = 16,
  parameter int DIMS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DIMS*WIDTH-1:0] extent,
  input  logic [DIMS*WIDTH-1:0] stride,
  input  logic [WIDTH-1:0]      offset,
  output logic [WIDTH-1:0]      addr_out,
  output logic                  addr_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ext_q  [DIMS];
  logic [WIDTH-1:0] str_q  [DIMS];
  logic [WIDTH-1:0] cnt_q  [DIMS];
  logic [WIDTH-1:0] part_q [DIMS];
  logic [WIDTH-1:0] off_q;
  logic [WIDTH-1:0] addr_sum;
  logic [DIMS-1:0]  at_max;
  logic [DIMS-1:0]  adv;
  logic             last;
  logic             advance;

  // Zero extent is a degenerate dimension that is permanently at max.
  always_comb begin
    at_max = '0;
    adv    = '0;
    for (int i = 0; i < DIMS; i++) begin
      at_max[i] = (ext_q[i] == '0) || (cnt_q[i] == ext_q[i] - 1'b1);
    end
    adv[0] = 1'b1;
    for (int i = 1; i < DIMS; i++) begin
      adv[i] = adv[i-1] & at_max[i-1];
    end
    last = &at_max;
  end

  always_comb begin
    addr_sum = off_q;
    for (int i = 0; i < DIMS; i++) begin
      addr_sum = addr_sum + part_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      IDLE: state_nxt = IDLE;
      RUN: begin
        if (step) begin
          if (last) state_nxt = DONE;
          else      advance   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // start overrides everything and drops a coincident step
    if (start) begin
      state_nxt = RUN;
      advance   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q <= '0;
      for (int i = 0; i < DIMS; i++) begin
        ext_q[i]  <= '0;
        str_q[i]  <= '0;
        cnt_q[i]  <= '0;
        part_q[i] <= '0;
      end
    end else if (start) begin
      off_q <= offset;
      for (int i = 0; i < DIMS; i++) begin
        ext_q[i]  <= extent[i*WIDTH +: WIDTH];
        str_q[i]  <= stride[i*WIDTH +: WIDTH];
        cnt_q[i]  <= '0;
        part_q[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < DIMS; i++) begin
        if (adv[i]) begin
          if (at_max[i]) begin
            cnt_q[i]  <= '0;
            part_q[i] <= '0;
          end else begin
            cnt_q[i]  <= cnt_q[i] + 1'b1;
            part_q[i] <= part_q[i] + str_q[i];
          end
        end
      end
    end
  end

  assign addr_out   = addr_sum;
  assign addr_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_affine_addr_gen.sv
// Scoreboard bench for affine_addr_gen: expected addresses come from a mixed-radix index model
// and are popped as each new scan point appears.
module tb_affine_addr_gen;
  localparam int W = 16;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst, start, step;
  logic [D*W-1:0] extent, stride;
  logic [W-1:0] offset;
  logic [W-1:0] addr_out;
  logic         addr_valid, busy, done;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;

  affine_addr_gen #(.WIDTH(W), .DIMS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .extent(extent), .stride(stride), .offset(offset),
    .addr_out(addr_out), .addr_valid(addr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expected(input int e0, input int e1, input int e2,
                               input int s0, input int s1, input int s2, input int off);
    int e[3];
    int s[3];
    int total, r, a;
    logic [W-1:0] v;
    e = '{(e0 < 1) ? 1 : e0, (e1 < 1) ? 1 : e1, (e2 < 1) ? 1 : e2};
    s = '{s0, s1, s2};
    exp_q.delete();
    total = e[0] * e[1] * e[2];
    for (int idx = 0; idx < total; idx++) begin
      r = idx;
      a = off;
      for (int d = 0; d < 3; d++) begin
        a = a + (r % e[d]) * s[d];
        r = r / e[d];
      end
      v = a[W-1:0];
      exp_q.push_back(v);
    end
  endtask

  task automatic do_start(input int e0, input int e1, input int e2,
                          input int s0, input int s1, input int s2, input int off,
                          input bit with_step);
    load_expected(e0, e1, e2, s0, s1, s2, off);
    extent = {W'(e2), W'(e1), W'(e0)};
    stride = {W'(s2), W'(s1), W'(s0)};
    offset = W'(off);
    start  = 1'b1;
    step   = with_step;
    tick();
    start  = 1'b0;
    step   = 1'b0;
    // configuration must be latched, so scramble the live inputs
    extent = {$urandom, $urandom};
    stride = {$urandom, $urandom};
    offset = W'($urandom);
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(addr_valid), 32'd1);
    check("start_done", 32'(done), 32'd0);
    cur = exp_q.pop_front();
    check("start_addr", 32'(addr_out), 32'(cur));
  endtask

  task automatic do_steps(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 2 == 1)) begin
        repeat (2) begin
          tick();
          check("gap_addr", 32'(addr_out), 32'(cur));
          check("gap_valid", 32'(addr_valid), 32'd1);
        end
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("step_addr", 32'(addr_out), 32'(cur));
        check("step_valid", 32'(addr_valid), 32'd1);
        check("step_done", 32'(done), 32'd0);
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(addr_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_addr", 32'(addr_out), 32'(cur));
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_addr", 32'(addr_out), 32'(cur));
        step = 1'b1;
        tick();
        step = 1'b0;
        check("idle_step_valid", 32'(addr_valid), 32'd0);
        check("idle_step_done", 32'(done), 32'd0);
        check("idle_step_addr", 32'(addr_out), 32'(cur));
      end
    end
  endtask

  task automatic run_full(input int e0, input int e1, input int e2,
                          input int s0, input int s1, input int s2, input int off,
                          input bit gaps);
    do_start(e0, e1, e2, s0, s1, s2, off, 1'b0);
    do_steps(exp_q.size() + 1, gaps);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    step   = 1'b0;
    extent = '0;
    stride = '0;
    offset = '0;
    tick();
    tick();
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("pre_start_valid", 32'(addr_valid), 32'd0);

    run_full(3, 2, 1, 1, 8, 0, 'h100, 1'b0);
    run_full(3, 2, 1, 1, 8, 0, 'h100, 1'b1);
    run_full(0, 1, 1, 5, 7, 9, 'h42, 1'b0);
    run_full(4, 1, 1, 1, 0, 0, 'hFFFE, 1'b0);
    run_full(2, 3, 2, 4, 'h10, 'h100, 'h20, 1'b0);
    run_full(2, 0, 3, 'h4, 'h55, 'h3000, 'hF000, 1'b1);

    // restart mid-scan with a coincident step
    do_start(3, 2, 1, 1, 8, 0, 'h100, 1'b0);
    do_steps(3, 1'b0);
    do_start(3, 2, 1, 1, 8, 0, 'h200, 1'b1);
    do_steps(exp_q.size() + 1, 1'b0);
    check("restart_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset mid-scan
    do_start(3, 2, 1, 1, 8, 0, 'h100, 1'b0);
    do_steps(2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_addr", 32'(addr_out), 32'd0);
    check("midrst_valid", 32'(addr_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("midrst_step_valid", 32'(addr_valid), 32'd0);
    check("midrst_step_addr", 32'(addr_out), 32'd0);
    run_full(3, 2, 1, 1, 8, 0, 'h100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
